// File: rtl/iq_scheduler_pkg.sv
// Shared defaults and helpers for the issue-queue scheduler.
`default_nettype none

package iq_scheduler_pkg;

  localparam int unsigned SLOTS_DEF     = 8;
  localparam int unsigned WIDTH_IDX_DEF = 3;
  localparam int unsigned WIDTH_BRM_DEF = 3;
  localparam int unsigned WIDTH_CNT_DEF = 4;
  localparam int unsigned LANES         = 4;
  localparam int unsigned STAT_W        = 16;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/iq_scheduler_oldest_select.sv
// Age-matrix picker: grants the candidate that no other candidate is older than.
`default_nettype none

module iq_scheduler_oldest_select
  import iq_scheduler_pkg::*;
#(
  parameter int unsigned SLOTS = SLOTS_DEF
) (
  input  logic [SLOTS-1:0]            cand_i,
  input  logic [SLOTS-1:0][SLOTS-1:0] older_i,
  output logic [SLOTS-1:0]            grant_o
);

  always_comb begin : p_pick
    logic blocked;
    grant_o = '0;
    blocked = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      blocked = 1'b0;
      for (int j = 0; j < SLOTS; j++) begin
        if (j != s && cand_i[j] && older_i[j][s]) begin
          blocked = 1'b1;
        end
      end
      grant_o[s] = cand_i[s] & ~blocked;
    end
  end

endmodule

`default_nettype wire

// File: rtl/iq_scheduler.sv
// iq_scheduler: slot allocation, age tracking, kill and 2-port oldest-ready select.
// Optional IQ_SCHED_STATS_EN adds dispatch-stall and issue counters.
`default_nettype none

module iq_scheduler
  import iq_scheduler_pkg::*;
#(
  parameter int unsigned SLOTS     = SLOTS_DEF,
  parameter int unsigned WIDTH_IDX = WIDTH_IDX_DEF,
  parameter int unsigned WIDTH_BRM = WIDTH_BRM_DEF,
  parameter int unsigned WIDTH_CNT = WIDTH_CNT_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [LANES-1:0]           i_disp_valid,
  input  logic [LANES*WIDTH_BRM-1:0] i_disp_brm,
  output logic                       o_disp_ready,
  output logic [LANES*WIDTH_IDX-1:0] o_alloc_idx,
  output logic [SLOTS-1:0]           o_alloc_we,
  input  logic [SLOTS-1:0]           i_slot_ready,
  input  logic [SLOTS*WIDTH_BRM-1:0] i_slot_brm,
  input  logic [WIDTH_BRM-1:0]       i_BrKill,
  input  logic [1:0]                 i_stall,
  output logic [SLOTS-1:0]           o_grant1,
  output logic [SLOTS-1:0]           o_grant2,
  output logic [1:0]                 o_issue_valid,
`ifdef IQ_SCHED_STATS_EN
  output logic [STAT_W-1:0]          o_stall_cnt,
  output logic [STAT_W-1:0]          o_issue_cnt,
`endif
  output logic [SLOTS-1:0]           o_slot_valid,
  output logic [WIDTH_CNT-1:0]       o_count
);

  logic [SLOTS-1:0]            valid_q, valid_d;
  logic [SLOTS-1:0][SLOTS-1:0] older_q, older_d;
  logic [WIDTH_CNT-1:0]        count_q, count_d;

  logic [SLOTS-1:0]            kill, cand1, cand2, sel1, sel2;
  logic [SLOTS-1:0]            grant1, grant2, survive, alloc;
  logic [LANES-1:0]            lane_live;
  logic [LANES*WIDTH_IDX-1:0]  alloc_idx;
  logic                        disp_ready, fire;

  always_comb begin
    kill = '0;
    for (int s = 0; s < SLOTS; s++) begin
      kill[s] = valid_q[s] & |(i_slot_brm[s*WIDTH_BRM +: WIDTH_BRM] & i_BrKill);
    end
    lane_live = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_live[l] = i_disp_valid[l] & ~|(i_disp_brm[l*WIDTH_BRM +: WIDTH_BRM] & i_BrKill);
    end
  end

  // Readiness looks only at registered occupancy; the whole group stalls otherwise.
  assign disp_ready = (count_q <= WIDTH_CNT'(SLOTS - LANES));
  assign fire       = i_rst_n & disp_ready & |i_disp_valid;

  // Surviving lanes take the lowest free slots in lane order, so lower lane => lower index.
  always_comb begin : p_alloc
    logic [SLOTS-1:0] free_rem;
    logic             found;
    free_rem  = ~valid_q;
    found     = 1'b0;
    alloc     = '0;
    alloc_idx = '0;
    for (int l = 0; l < LANES; l++) begin
      found = 1'b0;
      if (fire && lane_live[l]) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (!found && free_rem[s]) begin
            found       = 1'b1;
            free_rem[s] = 1'b0;
            alloc[s]    = 1'b1;
            alloc_idx[l*WIDTH_IDX +: WIDTH_IDX] = WIDTH_IDX'(s);
          end
        end
      end
    end
  end

  assign cand1 = valid_q & i_slot_ready & ~kill;

  iq_scheduler_oldest_select #(.SLOTS(SLOTS)) u_sel1 (
    .cand_i  (cand1),
    .older_i (older_q),
    .grant_o (sel1)
  );

  assign grant1 = i_stall[0] ? '0 : sel1;
  assign cand2  = cand1 & ~grant1;

  iq_scheduler_oldest_select #(.SLOTS(SLOTS)) u_sel2 (
    .cand_i  (cand2),
    .older_i (older_q),
    .grant_o (sel2)
  );

  assign grant2  = i_stall[1] ? '0 : sel2;
  assign survive = valid_q & ~kill & ~grant1 & ~grant2;
  assign valid_d = survive | alloc;
  assign count_d = WIDTH_CNT'(popcount16(16'(valid_d)));

  // A new slot is younger than every survivor; inside a group the lower index is older.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < SLOTS; i++) begin
      for (int j = 0; j < SLOTS; j++) begin
        if (alloc[i]) begin
          older_d[i][j] = alloc[j] & (i < j);
        end else if (alloc[j]) begin
          older_d[i][j] = survive[i];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      older_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      older_q <= older_d;
      count_q <= count_d;
    end
  end

`ifdef IQ_SCHED_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [STAT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [STAT_W:0]   issue_sum;

  assign stall_cnt_d = (|i_disp_valid && !disp_ready && stall_cnt_q != '1)
                       ? stall_cnt_q + 1'b1 : stall_cnt_q;
  assign issue_sum   = {1'b0, issue_cnt_q} + {{(STAT_W-1){1'b0}}, o_issue_valid[1] & o_issue_valid[0],
                                              o_issue_valid[1] ^ o_issue_valid[0]};
  assign issue_cnt_d = issue_sum[STAT_W] ? '1 : issue_sum[STAT_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
      issue_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_issue_cnt = issue_cnt_q;
`endif

  assign o_disp_ready  = disp_ready;
  assign o_alloc_we    = alloc;
  assign o_alloc_idx   = alloc_idx;
  assign o_grant1      = grant1;
  assign o_grant2      = grant2;
  assign o_issue_valid = {|grant2, |grant1};
  assign o_slot_valid  = valid_q;
  assign o_count       = count_q;

endmodule

`default_nettype wire

// File: tb/tb_iq_scheduler.sv
// Directed self-checking bench for iq_scheduler (default configuration).
`default_nettype none

module tb_iq_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  disp_valid;
  logic [11:0] disp_brm;
  logic        disp_ready;
  logic [11:0] alloc_idx;
  logic [7:0]  alloc_we;
  logic [7:0]  slot_ready;
  logic [23:0] slot_brm;
  logic [2:0]  brkill;
  logic [1:0]  stall;
  logic [7:0]  grant1, grant2;
  logic [1:0]  issue_valid;
  logic [7:0]  slot_valid;
  logic [3:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  iq_scheduler dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_disp_valid  (disp_valid),
    .i_disp_brm    (disp_brm),
    .o_disp_ready  (disp_ready),
    .o_alloc_idx   (alloc_idx),
    .o_alloc_we    (alloc_we),
    .i_slot_ready  (slot_ready),
    .i_slot_brm    (slot_brm),
    .i_BrKill      (brkill),
    .i_stall       (stall),
    .o_grant1      (grant1),
    .o_grant2      (grant2),
    .o_issue_valid (issue_valid),
    .o_slot_valid  (slot_valid),
    .o_count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    disp_valid = '0; disp_brm = '0; slot_ready = '0;
    slot_brm = '0; brkill = '0; stall = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycle_in(input logic [3:0] v, input logic [7:0] rdy);
    @(negedge clk);
    disp_valid = v;
    slot_ready = rdy;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_cmp++; if (slot_valid !== 8'h00) begin n_fail++; $display("FAIL reset_valid got %h exp 00", slot_valid); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", disp_ready); end
    n_cmp++; if (alloc_we !== 8'h00) begin n_fail++; $display("FAIL reset_alloc_we got %h exp 00", alloc_we); end
    n_cmp++; if (grant1 !== 8'h00 || grant2 !== 8'h00) begin n_fail++; $display("FAIL reset_grants got %h/%h exp 00/00", grant1, grant2); end
    n_cmp++; if (issue_valid !== 2'b00) begin n_fail++; $display("FAIL reset_issue_valid got %b exp 00", issue_valid); end
  endtask

  task automatic test_dispatch_fill();
    @(negedge clk);
    disp_valid = 4'b1111;
    #1;
    n_cmp++; if (alloc_we !== 8'h0F) begin n_fail++; $display("FAIL g1_alloc_we got %h exp 0f", alloc_we); end
    n_cmp++; if (alloc_idx !== 12'h688) begin n_fail++; $display("FAIL g1_alloc_idx got %h exp 688", alloc_idx); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd4) begin n_fail++; $display("FAIL g1_count got %0d exp 4", count); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL g1_ready got %b exp 1", disp_ready); end
    n_cmp++; if (slot_valid !== 8'h0F) begin n_fail++; $display("FAIL g1_valid got %h exp 0f", slot_valid); end
    @(negedge clk);
    #1;
    n_cmp++; if (alloc_we !== 8'hF0) begin n_fail++; $display("FAIL g2_alloc_we got %h exp f0", alloc_we); end
    n_cmp++; if (alloc_idx !== 12'hFAC) begin n_fail++; $display("FAIL g2_alloc_idx got %h exp fac", alloc_idx); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL g2_count got %0d exp 8", count); end
    n_cmp++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL g2_ready got %b exp 0", disp_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (alloc_we !== 8'h00) begin n_fail++; $display("FAIL full_alloc_we got %h exp 00", alloc_we); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd8) begin n_fail++; $display("FAIL full_count got %0d exp 8", count); end
    clear_inputs();
  endtask

  task automatic test_select_order();
    @(negedge clk);
    slot_ready = 8'hFF;
    #1;
    n_cmp++; if (grant1 !== 8'h01 || grant2 !== 8'h02) begin n_fail++; $display("FAIL sel_a got %h/%h exp 01/02", grant1, grant2); end
    n_cmp++; if (issue_valid !== 2'b11) begin n_fail++; $display("FAIL sel_a_iv got %b exp 11", issue_valid); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd6) begin n_fail++; $display("FAIL sel_a_count got %0d exp 6", count); end
    n_cmp++; if (disp_ready !== 1'b0) begin n_fail++; $display("FAIL sel_a_ready got %b exp 0", disp_ready); end
    @(negedge clk);
    #1;
    n_cmp++; if (grant1 !== 8'h04 || grant2 !== 8'h08) begin n_fail++; $display("FAIL sel_b got %h/%h exp 04/08", grant1, grant2); end
    @(posedge clk); #1;
    n_cmp++; if (slot_valid !== 8'hF0) begin n_fail++; $display("FAIL sel_b_valid got %h exp f0", slot_valid); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL sel_b_ready got %b exp 1", disp_ready); end
    clear_inputs();
  endtask

  task automatic test_stall();
    do_reset();
    cycle_in(4'b1111, 8'h00);
    cycle_in(4'b1111, 8'h00);
    @(negedge clk);
    slot_ready = 8'h24;
    stall = 2'b01;
    #1;
    n_cmp++; if (grant1 !== 8'h00 || grant2 !== 8'h04) begin n_fail++; $display("FAIL stall_grants got %h/%h exp 00/04", grant1, grant2); end
    @(posedge clk); #1;
    n_cmp++; if (slot_valid !== 8'hFB) begin n_fail++; $display("FAIL stall_valid got %h exp fb", slot_valid); end
    clear_inputs();
  endtask

  task automatic test_kill();
    do_reset();
    cycle_in(4'b1111, 8'h00);
    @(negedge clk);
    slot_brm   = 24'h000400;
    brkill     = 3'b010;
    slot_ready = 8'h08;
    disp_valid = 4'b0011;
    disp_brm   = 12'h002;
    #1;
    n_cmp++; if (grant1 !== 8'h00 || grant2 !== 8'h00) begin n_fail++; $display("FAIL kill_grants got %h/%h exp 00/00", grant1, grant2); end
    n_cmp++; if (alloc_we !== 8'h10) begin n_fail++; $display("FAIL kill_alloc_we got %h exp 10", alloc_we); end
    n_cmp++; if (alloc_idx !== 12'h020) begin n_fail++; $display("FAIL kill_alloc_idx got %h exp 020", alloc_idx); end
    @(posedge clk); #1;
    n_cmp++; if (slot_valid !== 8'h17) begin n_fail++; $display("FAIL kill_valid got %h exp 17", slot_valid); end
    n_cmp++; if (count !== 4'd4) begin n_fail++; $display("FAIL kill_count got %0d exp 4", count); end
    clear_inputs();
  endtask

  task automatic test_age_order();
    @(negedge clk);
    slot_ready = 8'h16;
    #1;
    n_cmp++; if (grant1 !== 8'h02 || grant2 !== 8'h04) begin n_fail++; $display("FAIL age_a got %h/%h exp 02/04", grant1, grant2); end
    @(posedge clk); #1;
    n_cmp++; if (slot_valid !== 8'h11) begin n_fail++; $display("FAIL age_a_valid got %h exp 11", slot_valid); end
    clear_inputs();
    @(negedge clk);
    disp_valid = 4'b1010;
    #1;
    n_cmp++; if (alloc_we !== 8'h06) begin n_fail++; $display("FAIL gap_alloc_we got %h exp 06", alloc_we); end
    n_cmp++; if (alloc_idx !== 12'h408) begin n_fail++; $display("FAIL gap_alloc_idx got %h exp 408", alloc_idx); end
    @(posedge clk); #1;
    n_cmp++; if (count !== 4'd4) begin n_fail++; $display("FAIL gap_count got %0d exp 4", count); end
    clear_inputs();
    @(negedge clk);
    slot_ready = 8'h16;
    #1;
    n_cmp++; if (grant1 !== 8'h10 || grant2 !== 8'h02) begin n_fail++; $display("FAIL age_b got %h/%h exp 10/02", grant1, grant2); end
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle_in(4'b1111, 8'h00);
    cycle_in(4'b1111, 8'h00);
    cycle_in(4'b0000, 8'hFF);
    n_cmp++; if (count !== 4'd6) begin n_fail++; $display("FAIL pre_arst_count got %0d exp 6", count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (slot_valid !== 8'h00) begin n_fail++; $display("FAIL arst_valid got %h exp 00", slot_valid); end
    n_cmp++; if (count !== 4'd0) begin n_fail++; $display("FAIL arst_count got %0d exp 0", count); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready got %b exp 1", disp_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_dispatch_fill();
    test_select_order();
    test_stall();
    test_kill();
    test_age_order();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
